// File: rtl/sum_accumulator_pkg.sv
// Shared types and default sizing for the frame sum accumulator.
// Imported by the interface, the saturating adder and the top level.
package sum_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_ACC_W = 16;
  localparam int DEF_LEN_W = 4;
  localparam int SUM_IN_W  = 9;

endpackage

// File: rtl/sum_accumulator_if.sv
// Frame control, sample input and result handshakes of the sum accumulator.
// Both handshakes (sum_valid/sum_ready and acc_valid/acc_ready) transfer on a rising edge when valid and ready are both high.
interface sum_accumulator_if
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) ();

  logic                start;
  logic [LEN_W-1:0]    len;
  logic [SUM_IN_W-1:0] sum_in;
  logic                sum_valid;
  logic                sum_ready;
  logic [ACC_W-1:0]    acc_out;
  logic                acc_valid;
  logic                acc_ready;
  logic                ovf;
  logic                busy;
  state_t              dbg_state;

  modport master (
    output start, len, sum_in, sum_valid, acc_ready,
    input  sum_ready, acc_out, acc_valid, ovf, busy, dbg_state
  );

  modport slave (
    input  start, len, sum_in, sum_valid, acc_ready,
    output sum_ready, acc_out, acc_valid, ovf, busy, dbg_state
  );

endinterface

// File: rtl/sum_accumulator_sat_add.sv
// Saturating add of a 9-bit unsigned operand onto an ACC_W-bit accumulator.
// The extra carry bit of the unbounded sum is the overflow indication.
module sat_add
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]    i_acc,
  input  logic [SUM_IN_W-1:0] i_operand,
  output logic [ACC_W-1:0]    o_sum,
  output logic                o_ovf
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, i_acc} + {{(ACC_W + 1 - SUM_IN_W){1'b0}}, i_operand};
  assign o_ovf  = w_full[ACC_W];
  assign o_sum  = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a frame of 9-bit sums into a saturating ACC_W-bit total and
// holds the result until the consumer takes it.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  sum_accumulator_if.slave   bus
);

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [LEN_W:0]     r_len;
  logic [LEN_W:0]     r_cnt;

  logic [LEN_W:0]     w_len_eff;
  logic [ACC_W-1:0]   w_sum;
  logic               w_add_ovf;
  logic               w_accept;
  logic               w_last;
  logic               w_sum_ready;
  logic               w_acc_valid;
  logic               w_busy;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .i_acc     (r_acc),
    .i_operand (bus.sum_in),
    .o_sum     (w_sum),
    .o_ovf     (w_add_ovf)
  );

  // A zero length field encodes the largest frame, 2**LEN_W samples.
  assign w_len_eff = (bus.len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.len};
  assign w_accept  = (r_state == ST_ACCUM) && bus.sum_valid;
  assign w_last    = (r_cnt == (r_len - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sum_ready  = 1'b0;
    w_acc_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        w_sum_ready = 1'b1;
        w_busy      = 1'b1;
        if (bus.sum_valid && w_last) w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        w_acc_valid = 1'b1;
        w_busy      = 1'b1;
        if (bus.acc_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result registers only move on a start in IDLE or an accepted sample,
  // so they stay frozen through HOLD and after the frame is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_len <= '0;
      r_cnt <= '0;
    end else if ((r_state == ST_IDLE) && bus.start) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_len <= w_len_eff;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_ovf <= r_ovf | w_add_ovf;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.sum_ready = w_sum_ready;
  assign bus.acc_valid = w_acc_valid;
  assign bus.busy      = w_busy;
  assign bus.acc_out   = r_acc;
  assign bus.ovf       = r_ovf;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a 16-bit instance for the main scenarios
// and a 12-bit instance to exercise saturation.
module tb_sum_accumulator;
  import sum_accumulator_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sum_accumulator_if #(.ACC_W(16), .LEN_W(4)) b16 ();
  sum_accumulator_if #(.ACC_W(12), .LEN_W(4)) b12 ();

  sum_accumulator #(.ACC_W(16), .LEN_W(4)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (b16.slave)
  );

  sum_accumulator #(.ACC_W(12), .LEN_W(4)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (b12.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b16.start = 1'b0; b16.len = 4'd0; b16.sum_in = 9'd0; b16.sum_valid = 1'b0; b16.acc_ready = 1'b0;
    b12.start = 1'b0; b12.len = 4'd0; b12.sum_in = 9'd0; b12.sum_valid = 1'b0; b12.acc_ready = 1'b0;
  endtask

  task automatic start16(input logic [3:0] l);
    b16.start = 1'b1;
    b16.len   = l;
    tick();
    b16.start = 1'b0;
  endtask

  task automatic sample16(input logic [8:0] v);
    b16.sum_in    = v;
    b16.sum_valid = 1'b1;
    tick();
    b16.sum_valid = 1'b0;
  endtask

  task automatic release16();
    b16.acc_ready = 1'b1;
    tick();
    b16.acc_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    total++;
    if (b16.dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", b16.dbg_state, ST_IDLE); end
    total++;
    if ({b16.sum_ready, b16.acc_valid, b16.busy, b16.ovf} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {b16.sum_ready, b16.acc_valid, b16.busy, b16.ovf});
    end
    total++;
    if (b16.acc_out !== 16'd0) begin bad++; $display("FAIL reset_acc got=%0d exp=0", b16.acc_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [8:0] vals [4];
    vals[0] = 9'd10; vals[1] = 9'd20; vals[2] = 9'd30; vals[3] = 9'd510;
    start16(4'd4);
    total++;
    if ({b16.sum_ready, b16.busy, b16.acc_valid} !== 3'b110) begin
      bad++; $display("FAIL basic_enter_accum got=%b exp=110", {b16.sum_ready, b16.busy, b16.acc_valid});
    end
    for (int i = 0; i < 4; i++) begin
      sample16(vals[i]);
      if (i < 3) begin
        total++;
        if (b16.acc_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid i=%0d got=%b exp=0", i, b16.acc_valid); end
      end
    end
    total++;
    if (b16.acc_valid !== 1'b1) begin bad++; $display("FAIL basic_latency got=%b exp=1", b16.acc_valid); end
    total++;
    if (b16.acc_out !== 16'd570) begin bad++; $display("FAIL basic_sum got=%0d exp=570", b16.acc_out); end
    total++;
    if ({b16.ovf, b16.sum_ready} !== 2'b00) begin bad++; $display("FAIL basic_ovf_ready got=%b exp=00", {b16.ovf, b16.sum_ready}); end
    release16();
    total++;
    if ({b16.dbg_state, b16.acc_valid, b16.busy} !== {ST_IDLE, 2'b00}) begin
      bad++; $display("FAIL basic_release got=%b exp=%b", {b16.dbg_state, b16.acc_valid, b16.busy}, {ST_IDLE, 2'b00});
    end
  endtask

  task automatic test_len_zero();
    start16(4'd0);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (b16.sum_ready !== 1'b1) begin bad++; $display("FAIL len0_ready i=%0d got=%b exp=1", i, b16.sum_ready); end
      sample16(9'd510);
    end
    total++;
    if (b16.sum_ready !== 1'b0) begin bad++; $display("FAIL len0_ready_drop got=%b exp=0", b16.sum_ready); end
    total++;
    if (b16.acc_out !== 16'd8160) begin bad++; $display("FAIL len0_sum got=%0d exp=8160", b16.acc_out); end
    total++;
    if ({b16.acc_valid, b16.ovf} !== 2'b10) begin bad++; $display("FAIL len0_valid_ovf got=%b exp=10", {b16.acc_valid, b16.ovf}); end
    release16();
  endtask

  task automatic test_saturation();
    b12.start = 1'b1; b12.len = 4'd0;
    tick();
    b12.start = 1'b0;
    b12.sum_in = 9'd510;
    b12.sum_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 7) begin
        total++;
        if ({b12.ovf, b12.acc_out} !== {1'b0, 12'd4080}) begin
          bad++; $display("FAIL sat_before got ovf=%b acc=%0d exp ovf=0 acc=4080", b12.ovf, b12.acc_out);
        end
      end
      if (i == 8) begin
        total++;
        if ({b12.ovf, b12.acc_out} !== {1'b1, 12'd4095}) begin
          bad++; $display("FAIL sat_first got ovf=%b acc=%0d exp ovf=1 acc=4095", b12.ovf, b12.acc_out);
        end
      end
    end
    b12.sum_valid = 1'b0;
    total++;
    if ({b12.acc_valid, b12.ovf, b12.acc_out} !== {2'b11, 12'd4095}) begin
      bad++; $display("FAIL sat_final got valid=%b ovf=%b acc=%0d exp valid=1 ovf=1 acc=4095", b12.acc_valid, b12.ovf, b12.acc_out);
    end
    b12.acc_ready = 1'b1;
    tick();
    b12.acc_ready = 1'b0;
    total++;
    if (b12.ovf !== 1'b1) begin bad++; $display("FAIL sat_sticky_idle got=%b exp=1", b12.ovf); end
    b12.start = 1'b1; b12.len = 4'd1;
    tick();
    b12.start = 1'b0;
    total++;
    if ({b12.ovf, b12.acc_out} !== {1'b0, 12'd0}) begin
      bad++; $display("FAIL sat_clear_on_start got ovf=%b acc=%0d exp ovf=0 acc=0", b12.ovf, b12.acc_out);
    end
    b12.sum_in = 9'd5; b12.sum_valid = 1'b1;
    tick();
    b12.sum_valid = 1'b0;
    total++;
    if ({b12.acc_valid, b12.ovf, b12.acc_out} !== {2'b10, 12'd5}) begin
      bad++; $display("FAIL sat_next_frame got valid=%b ovf=%b acc=%0d exp valid=1 ovf=0 acc=5", b12.acc_valid, b12.ovf, b12.acc_out);
    end
    b12.acc_ready = 1'b1;
    tick();
    b12.acc_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [8:0]  vals [3];
    logic [15:0] run;
    vals[0] = 9'd100; vals[1] = 9'd200; vals[2] = 9'd300;
    run = 16'd0;
    start16(4'd3);
    for (int i = 0; i < 3; i++) begin
      b16.sum_in = 9'h1FF;
      b16.sum_valid = 1'b0;
      tick();
      total++;
      if ({b16.dbg_state, b16.acc_out} !== {ST_ACCUM, run}) begin
        bad++; $display("FAIL bp_gap i=%0d got state=%0d acc=%0d exp state=%0d acc=%0d", i, b16.dbg_state, b16.acc_out, ST_ACCUM, run);
      end
      sample16(vals[i]);
      run = run + 16'(vals[i]);
    end
    for (int c = 0; c < 5; c++) begin
      b16.start = (c == 1 || c == 3);
      b16.len   = 4'd2;
      tick();
      total++;
      if ({b16.acc_valid, b16.acc_out, b16.dbg_state} !== {1'b1, 16'd600, ST_HOLD}) begin
        bad++; $display("FAIL bp_hold c=%0d got valid=%b acc=%0d state=%0d exp valid=1 acc=600 state=%0d", c, b16.acc_valid, b16.acc_out, b16.dbg_state, ST_HOLD);
      end
    end
    b16.start = 1'b0;
    release16();
    total++;
    if (b16.dbg_state !== ST_IDLE) begin bad++; $display("FAIL bp_release got=%0d exp=%0d", b16.dbg_state, ST_IDLE); end
  endtask

  task automatic test_reset_midframe();
    start16(4'd4);
    sample16(9'd50);
    sample16(9'd60);
    total++;
    if (b16.acc_out !== 16'd110) begin bad++; $display("FAIL rstmid_partial got=%0d exp=110", b16.acc_out); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({b16.dbg_state, b16.acc_out, b16.sum_ready, b16.acc_valid, b16.busy, b16.ovf} !== {ST_IDLE, 16'd0, 4'b0000}) begin
      bad++; $display("FAIL rstmid_async got state=%0d acc=%0d flags=%b exp state=0 acc=0 flags=0000",
                      b16.dbg_state, b16.acc_out, {b16.sum_ready, b16.acc_valid, b16.busy, b16.ovf});
    end
    tick();
    rst = 1'b0;
    tick();
    tick();
    total++;
    if ({b16.acc_valid, b16.busy, b16.acc_out} !== {2'b00, 16'd0}) begin
      bad++; $display("FAIL rstmid_no_emit got valid=%b busy=%b acc=%0d exp 0 0 0", b16.acc_valid, b16.busy, b16.acc_out);
    end
    start16(4'd1);
    sample16(9'd7);
    total++;
    if ({b16.acc_valid, b16.acc_out} !== {1'b1, 16'd7}) begin
      bad++; $display("FAIL rstmid_new_frame got valid=%b acc=%0d exp valid=1 acc=7", b16.acc_valid, b16.acc_out);
    end
    release16();
  endtask

  task automatic test_back_to_back();
    start16(4'd2);
    sample16(9'd1);
    sample16(9'd2);
    total++;
    if ({b16.acc_valid, b16.acc_out} !== {1'b1, 16'd3}) begin
      bad++; $display("FAIL b2b_first got valid=%b acc=%0d exp valid=1 acc=3", b16.acc_valid, b16.acc_out);
    end
    b16.acc_ready = 1'b1;
    b16.start     = 1'b1;
    b16.len       = 4'd1;
    tick();
    b16.acc_ready = 1'b0;
    b16.start     = 1'b0;
    total++;
    if ({b16.dbg_state, b16.busy, b16.acc_out} !== {ST_IDLE, 1'b0, 16'd3}) begin
      bad++; $display("FAIL b2b_coincident got state=%0d busy=%b acc=%0d exp state=%0d busy=0 acc=3", b16.dbg_state, b16.busy, b16.acc_out, ST_IDLE);
    end
    start16(4'd1);
    total++;
    if ({b16.dbg_state, b16.acc_out} !== {ST_ACCUM, 16'd0}) begin
      bad++; $display("FAIL b2b_restart got state=%0d acc=%0d exp state=%0d acc=0", b16.dbg_state, b16.acc_out, ST_ACCUM);
    end
    sample16(9'd9);
    total++;
    if ({b16.acc_valid, b16.acc_out} !== {1'b1, 16'd9}) begin
      bad++; $display("FAIL b2b_second got valid=%b acc=%0d exp valid=1 acc=9", b16.acc_valid, b16.acc_out);
    end
    release16();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_len_zero();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
